conv_layer_ctrl: RTL and testbench
==================================

// Module: conv_layer_ctrl
// PURPOSE
//  Parametrised control FSM for one CNN convolution layer. It supersedes the single-shot transmission FSM.
//  Per output channel, it loads the kernel into the weight buffer, then scans every output pixel.
//  For each pixel it issues one feature-map/weight read per kernel tap and drives MAC enables aligned to read data.
//  Each finished pixel is handed to the output writer with a valid/ready handshake.
// PARAMETERS
//  IMG_W    28  input feature-map width (pixels); IMG_W >= KSIZE
//  IMG_H    28  input feature-map height (pixels); IMG_H >= KSIZE
//  KSIZE    3   square kernel edge
//  STRIDE   1   window step, both axes
//  IN_CH    1   input channels accumulated per output pixel
//  OUT_CH   4   output channels (kernels) computed in sequence
//  ADDR_W   16  width of all address outputs
//  Derived: OUT_W=(IMG_W-KSIZE)/STRIDE+1, OUT_H=(IMG_H-KSIZE)/STRIDE+1, NTAP=KSIZE*KSIZE*IN_CH
// PORTS
//  clk                 in   1       system clock, rising edge
//  rst                 in   1       asynchronous, active-low reset
//  transmission_start  in   1       start pulse; sampled only in IDLE
//  w_in_valid          in   1       weight word available from loader
//  w_in_ready          out  1       controller accepts weight word
//  w_wr_en             out  1       weight buffer write strobe (= w_in_valid & w_in_ready)
//  w_wr_addr           out  ADDR_W  weight buffer write address, 0..NTAP-1
//  pix_rd_en           out  1       feature-map read strobe; data returns 1 cycle later
//  pix_addr            out  ADDR_W  ic*IMG_W*IMG_H + (oy*STRIDE+ky)*IMG_W + ox*STRIDE+kx
//  w_rd_addr           out  ADDR_W  (ic*KSIZE+ky)*KSIZE+kx, issued with pix_rd_en
//  mac_clr             out  1       with first tap data of a window: load product, discard accumulator
//  mac_en              out  1       tap data valid at MAC inputs
//  mac_last            out  1       with last tap data of a window
//  out_valid           out  1       accumulated pixel ready for writer
//  out_ready           in   1       writer accepts pixel
//  out_addr            out  ADDR_W  oc*OUT_W*OUT_H + oy*OUT_W + ox
//  busy                out  1       high in every state except IDLE
//  done                out  1       one-cycle pulse after last pixel of last channel is accepted
// BEHAVIOUR
//  Reset (rst=0, any time, async): state=IDLE; all counters 0; all outputs 0; delay pipe flushed.
//  States: IDLE, LOAD_W, CONV, DRAIN, OUTPUT, DONE.
//  IDLE:   transmission_start=1 -> LOAD_W with oc=0. All other inputs are ignored.
//  LOAD_W: w_in_ready=1. Each accepted word writes w_wr_addr, then increments it.
//          Stalls while w_in_valid=0. Word NTAP-1 accepted -> CONV, oy=ox=0.
//  CONV:   pix_rd_en=1 every cycle, one tap per cycle. Taps run kx fastest, then ky, then ic.
//          Tap NTAP-1 issued -> DRAIN.
//  Delay pipe: a 1-cycle register of (rd_en, first, last) drives mac_en/mac_clr/mac_last.
//          mac_clr is high on tap 0. mac_last is high on tap NTAP-1. With NTAP=1, both are high together.
//  DRAIN:  exactly 1 cycle; mac_last is high here. -> OUTPUT.
//  OUTPUT: out_valid=1 and out_addr is held stable until out_ready=1. No reads are issued.
//          On accept: ox++. At ox=OUT_W-1: ox=0, oy++. Next state on accept:
//            more pixels in the channel   -> CONV, next window.
//            last pixel, oc<OUT_CH-1      -> LOAD_W, oc++, w_wr_addr=0.
//            last pixel, oc=OUT_CH-1      -> DONE.
//  DONE:   done=1 for one cycle -> IDLE. transmission_start is ignored in DONE; it is accepted from the next IDLE cycle.
//  Latency: last read issued at cycle t -> mac_last at t+1 -> out_valid at t+2.
//  Window throughput without stall: NTAP+2 cycles per pixel.
//  transmission_start while busy=1: ignored, with no restart.
//  Address arithmetic: unsigned, truncated to ADDR_W. The integrator sizes ADDR_W >= clog2(IN_CH*IMG_W*IMG_H).
//  Simultaneous out_valid & out_ready in the first OUTPUT cycle: accept in that cycle (0 stall).
// TESTING
//  1. IMG 4x4, K3, S1, IN1, OUT1, start pulse, 9 weights with no gaps.
//     -> 4 windows; pix_addr of window 0 = 0,1,2,4,5,6,8,9,10; out_addr 0..3; done once; 4*11 cycles in CONV..OUTPUT.
//  2. IMG 5x5, K3, S2, IN2, OUT2.
//     -> 4 px/channel, NTAP=18; window (1,1) ic1 first addr = 25+2*5+2 = 37; out_addr 0..7; LOAD_W is re-entered once.
//  3. Drop w_in_valid for 3 cycles mid-load.
//     -> w_wr_addr holds, no w_wr_en, load completes with 9 writes.
//  4. Hold out_ready=0 for 5 cycles on pixel 1.
//     -> out_valid and out_addr=1 stable, pix_rd_en=0 throughout, resumes on release.
//  5. Pulse transmission_start while in CONV; pulse it again in the DONE cycle.
//     -> both ignored. A start in the next IDLE cycle begins a new layer.
//  6. Drive rst=0 asynchronously mid-CONV.
//     -> busy, pix_rd_en, mac_en and out_valid go 0 immediately. After release, the FSM sits in IDLE until the next start.

Source files
------------

// File: rtl/conv_layer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv_layer_ctrl
// Purpose  : Control sequencer for one CNN convolution layer. For each output
//            channel it loads the kernel into the weight buffer, then walks all
//            output pixels. Every pixel issues one feature-map/weight read per
//            kernel tap, drives MAC enables aligned to the returning read data
//            and hands the accumulated pixel to the writer over valid/ready.
// Ports    : clk                 rising-edge clock
//            rst                 asynchronous active-low reset
//            transmission_start  start pulse, honoured only while idle
//            w_in_valid/ready    weight loader handshake
//            w_wr_en/w_wr_addr   weight buffer write port
//            pix_rd_en/pix_addr  feature-map read port (data one cycle later)
//            w_rd_addr           weight buffer read address, paired with pix_rd_en
//            mac_clr/en/last     MAC controls aligned with the read data
//            out_valid/ready     output writer handshake, out_addr = pixel slot
//            busy                high whenever a layer is in progress
//            done                one-cycle pulse when the layer completes
// Revision : 1.0  initial release
// ============================================================================
module conv_layer_ctrl #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int KSIZE  = 3,
    parameter int STRIDE = 1,
    parameter int IN_CH  = 1,
    parameter int OUT_CH = 4,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              transmission_start,
    input  logic              w_in_valid,
    output logic              w_in_ready,
    output logic              w_wr_en,
    output logic [ADDR_W-1:0] w_wr_addr,
    output logic              pix_rd_en,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [ADDR_W-1:0] w_rd_addr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              mac_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);

    // ------------------------------------------------------------------
    // Derived geometry
    // ------------------------------------------------------------------
    localparam int OUT_W = (IMG_W - KSIZE) / STRIDE + 1;
    localparam int OUT_H = (IMG_H - KSIZE) / STRIDE + 1;
    localparam int NTAP  = KSIZE * KSIZE * IN_CH;

    // Counter widths; a single-value counter still needs one bit.
    localparam int K_W  = (KSIZE  > 1) ? $clog2(KSIZE)  : 1;
    localparam int IC_W = (IN_CH  > 1) ? $clog2(IN_CH)  : 1;
    localparam int OX_W = (OUT_W  > 1) ? $clog2(OUT_W)  : 1;
    localparam int OY_W = (OUT_H  > 1) ? $clog2(OUT_H)  : 1;
    localparam int OC_W = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
    localparam int WA_W = (NTAP   > 1) ? $clog2(NTAP)   : 1;

    // Terminal counts
    localparam logic [K_W-1:0]  K_LAST  = K_W'(KSIZE - 1);
    localparam logic [IC_W-1:0] IC_LAST = IC_W'(IN_CH - 1);
    localparam logic [OX_W-1:0] OX_LAST = OX_W'(OUT_W - 1);
    localparam logic [OY_W-1:0] OY_LAST = OY_W'(OUT_H - 1);
    localparam logic [OC_W-1:0] OC_LAST = OC_W'(OUT_CH - 1);
    localparam logic [WA_W-1:0] WA_LAST = WA_W'(NTAP - 1);

    // Address-arithmetic constants, pre-truncated to the address width
    localparam logic [ADDR_W-1:0] A_IMG_W   = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] A_PLANE   = ADDR_W'(IMG_W * IMG_H);
    localparam logic [ADDR_W-1:0] A_STRIDE  = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] A_KSIZE   = ADDR_W'(KSIZE);
    localparam logic [ADDR_W-1:0] A_OUT_W   = ADDR_W'(OUT_W);
    localparam logic [ADDR_W-1:0] A_OUT_PIX = ADDR_W'(OUT_W * OUT_H);

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_CONV   = 3'd2,
        S_DRAIN  = 3'd3,
        S_OUTPUT = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [OC_W-1:0]   oc_q, oc_d;
    logic [OY_W-1:0]   oy_q, oy_d;
    logic [OX_W-1:0]   ox_q, ox_d;
    logic [IC_W-1:0]   ic_q, ic_d;
    logic [K_W-1:0]    ky_q, ky_d;
    logic [K_W-1:0]    kx_q, kx_d;
    logic [WA_W-1:0]   wa_q, wa_d;

    // One-cycle delay pipe so MAC controls line up with read data
    logic              rd_q, rd_d;
    logic              first_q, first_d;
    logic              last_q, last_d;

    logic              tap_first;
    logic              tap_last;
    logic              pix_last_col;
    logic              pix_last_row;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            oc_q    <= '0;
            oy_q    <= '0;
            ox_q    <= '0;
            ic_q    <= '0;
            ky_q    <= '0;
            kx_q    <= '0;
            wa_q    <= '0;
            rd_q    <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            oc_q    <= oc_d;
            oy_q    <= oy_d;
            ox_q    <= ox_d;
            ic_q    <= ic_d;
            ky_q    <= ky_d;
            kx_q    <= kx_d;
            wa_q    <= wa_d;
            rd_q    <= rd_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        oc_d         = oc_q;
        oy_d         = oy_q;
        ox_d         = ox_q;
        ic_d         = ic_q;
        ky_d         = ky_q;
        kx_d         = kx_q;
        wa_d         = wa_q;
        w_in_ready   = 1'b0;
        w_wr_en      = 1'b0;
        pix_rd_en    = 1'b0;
        out_valid    = 1'b0;
        done         = 1'b0;

        tap_first    = (kx_q == '0) && (ky_q == '0) && (ic_q == '0);
        tap_last     = (kx_q == K_LAST) && (ky_q == K_LAST) && (ic_q == IC_LAST);
        pix_last_col = (ox_q == OX_LAST);
        pix_last_row = (oy_q == OY_LAST);

        case (state_q)
            S_IDLE: begin
                if (transmission_start) begin
                    state_d = S_LOAD_W;
                    oc_d    = '0;
                    oy_d    = '0;
                    ox_d    = '0;
                    ic_d    = '0;
                    ky_d    = '0;
                    kx_d    = '0;
                    wa_d    = '0;
                end
            end

            S_LOAD_W: begin
                w_in_ready = 1'b1;
                w_wr_en    = w_in_valid;
                if (w_in_valid) begin
                    if (wa_q == WA_LAST) begin
                        // Kernel complete: rewind the write pointer for the
                        // next channel and start at the first window.
                        wa_d    = '0;
                        oy_d    = '0;
                        ox_d    = '0;
                        ic_d    = '0;
                        ky_d    = '0;
                        kx_d    = '0;
                        state_d = S_CONV;
                    end else begin
                        wa_d = wa_q + WA_W'(1);
                    end
                end
            end

            S_CONV: begin
                pix_rd_en = 1'b1;
                // Tap order: kx fastest, then ky, then ic. All three wrap to
                // zero together on the final tap, ready for the next window.
                if (kx_q != K_LAST) begin
                    kx_d = kx_q + K_W'(1);
                end else begin
                    kx_d = '0;
                    if (ky_q != K_LAST) begin
                        ky_d = ky_q + K_W'(1);
                    end else begin
                        ky_d = '0;
                        ic_d = (ic_q == IC_LAST) ? '0 : ic_q + IC_W'(1);
                    end
                end
                if (tap_last) begin
                    state_d = S_DRAIN;
                end
            end

            S_DRAIN: begin
                // Last tap's data is at the MAC this cycle.
                state_d = S_OUTPUT;
            end

            S_OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (pix_last_col) begin
                        ox_d = '0;
                        oy_d = pix_last_row ? '0 : oy_q + OY_W'(1);
                    end else begin
                        ox_d = ox_q + OX_W'(1);
                    end

                    if (pix_last_col && pix_last_row) begin
                        if (oc_q == OC_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            oc_d    = oc_q + OC_W'(1);
                            wa_d    = '0;
                            state_d = S_LOAD_W;
                        end
                    end else begin
                        state_d = S_CONV;
                    end
                end
            end

            S_DONE: begin
                done    = 1'b1;
                oc_d    = '0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        rd_d    = pix_rd_en;
        first_d = pix_rd_en & tap_first;
        last_d  = pix_rd_en & tap_last;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy     = (state_q != S_IDLE);
    assign mac_en   = rd_q;
    assign mac_clr  = first_q;
    assign mac_last = last_q;

    assign w_wr_addr = ADDR_W'(wa_q);

    assign pix_addr  = A_PLANE * ADDR_W'(ic_q)
                     + (ADDR_W'(oy_q) * A_STRIDE + ADDR_W'(ky_q)) * A_IMG_W
                     + ADDR_W'(ox_q) * A_STRIDE + ADDR_W'(kx_q);

    assign w_rd_addr = (ADDR_W'(ic_q) * A_KSIZE + ADDR_W'(ky_q)) * A_KSIZE
                     + ADDR_W'(kx_q);

    assign out_addr  = A_OUT_PIX * ADDR_W'(oc_q)
                     + ADDR_W'(oy_q) * A_OUT_W + ADDR_W'(ox_q);

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_layer_ctrl
// Purpose  : Self-checking bench for conv_layer_ctrl (5x5 image, 3x3 kernel,
//            stride 2, two input and two output channels). Expected traffic
//            is generated as address lists straight from the layer geometry;
//            a per-cycle compare process walks those lists alongside the DUT.
// Revision : 1.0  initial release
// ============================================================================
module tb_conv_layer_ctrl;

    localparam int P_W    = 5;
    localparam int P_H    = 5;
    localparam int P_K    = 3;
    localparam int P_S    = 2;
    localparam int P_IC   = 2;
    localparam int P_OC   = 2;
    localparam int P_AW   = 16;
    localparam int P_OW   = (P_W - P_K) / P_S + 1;
    localparam int P_OH   = (P_H - P_K) / P_S + 1;
    localparam int P_NTAP = P_K * P_K * P_IC;
    localparam int P_NPIX = P_OW * P_OH;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            transmission_start = 1'b0;
    logic            w_in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic            w_in_ready, w_wr_en, pix_rd_en;
    logic            mac_clr, mac_en, mac_last, out_valid, busy, done;
    logic [P_AW-1:0] w_wr_addr, pix_addr, w_rd_addr, out_addr;

    conv_layer_ctrl #(
        .IMG_W (P_W), .IMG_H (P_H), .KSIZE (P_K), .STRIDE (P_S),
        .IN_CH (P_IC), .OUT_CH (P_OC), .ADDR_W (P_AW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .transmission_start (transmission_start),
        .w_in_valid         (w_in_valid),
        .w_in_ready         (w_in_ready),
        .w_wr_en            (w_wr_en),
        .w_wr_addr          (w_wr_addr),
        .pix_rd_en          (pix_rd_en),
        .pix_addr           (pix_addr),
        .w_rd_addr          (w_rd_addr),
        .mac_clr            (mac_clr),
        .mac_en             (mac_en),
        .mac_last           (mac_last),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_addr           (out_addr),
        .busy               (busy),
        .done               (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model state ----------------
    bit              layer_active, exp_load, done_now, done_pend, pend_out, prev_rd;
    int              wr_cnt, rd_left, prev_tap, ov_delay, px_cnt;
    logic [P_AW-1:0] q_wr[$];
    logic [P_AW-1:0] q_pix[$];
    logic [P_AW-1:0] q_wra[$];
    logic [P_AW-1:0] q_out[$];

    // Window (0,0) feature-map addresses, worked out by hand
    logic [P_AW-1:0] win0 [P_NTAP] = '{16'd0, 16'd1, 16'd2, 16'd5, 16'd6, 16'd7,
                                       16'd10, 16'd11, 16'd12, 16'd25, 16'd26, 16'd27,
                                       16'd30, 16'd31, 16'd32, 16'd35, 16'd36, 16'd37};

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chka(input string nm, input logic [P_AW-1:0] act, input logic [P_AW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        layer_active = 0; exp_load = 0; done_now = 0; done_pend = 0;
        pend_out = 0; prev_rd = 0;
        wr_cnt = 0; rd_left = 0; prev_tap = 0; ov_delay = 0; px_cnt = 0;
        q_wr.delete(); q_pix.delete(); q_wra.delete(); q_out.delete();
    endtask

    // Full expected traffic of one layer, straight from the address formulas
    task automatic build_queues();
        q_wr.delete(); q_pix.delete(); q_wra.delete(); q_out.delete();
        for (int oc = 0; oc < P_OC; oc++) begin
            for (int t = 0; t < P_NTAP; t++) q_wr.push_back(P_AW'(t));
            for (int oy = 0; oy < P_OH; oy++) begin
                for (int ox = 0; ox < P_OW; ox++) begin
                    q_out.push_back(P_AW'(oc * P_NPIX + oy * P_OW + ox));
                    for (int ic = 0; ic < P_IC; ic++)
                        for (int ky = 0; ky < P_K; ky++)
                            for (int kx = 0; kx < P_K; kx++) begin
                                q_pix.push_back(P_AW'(ic * P_W * P_H + (oy * P_S + ky) * P_W
                                                      + ox * P_S + kx));
                                q_wra.push_back(P_AW'((ic * P_K + ky) * P_K + kx));
                            end
                end
            end
        end
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle
    task automatic monitor();
        bit do_wr, do_rd, do_acc;
        forever begin
            @(negedge clk);
            if (!rst) begin
                model_clear();
                chk1("rst_busy", busy, 1'b0);
                chk1("rst_w_in_ready", w_in_ready, 1'b0);
                chk1("rst_w_wr_en", w_wr_en, 1'b0);
                chk1("rst_pix_rd_en", pix_rd_en, 1'b0);
                chk1("rst_mac_en", mac_en, 1'b0);
                chk1("rst_mac_clr", mac_clr, 1'b0);
                chk1("rst_mac_last", mac_last, 1'b0);
                chk1("rst_out_valid", out_valid, 1'b0);
                chk1("rst_done", done, 1'b0);
                chka("rst_pix_addr", pix_addr, '0);
                chka("rst_out_addr", out_addr, '0);
                chka("rst_w_wr_addr", w_wr_addr, '0);
                chka("rst_w_rd_addr", w_rd_addr, '0);
            end else begin
                done_now  = done_pend;
                done_pend = 0;
                if (ov_delay > 0) begin
                    ov_delay--;
                    if (ov_delay == 0) pend_out = 1;
                end
                do_wr  = exp_load && w_in_valid;
                do_rd  = (rd_left > 0);
                do_acc = pend_out && out_ready;

                chk1("busy", busy, layer_active);
                chk1("done", done, done_now);
                chk1("w_in_ready", w_in_ready, exp_load);
                chk1("w_wr_en", w_wr_en, do_wr);
                if (do_wr) chka("w_wr_addr", w_wr_addr, q_wr[0]);
                chk1("pix_rd_en", pix_rd_en, do_rd);
                if (do_rd) begin
                    chka("pix_addr", pix_addr, q_pix[0]);
                    chka("w_rd_addr", w_rd_addr, q_wra[0]);
                end
                chk1("mac_en", mac_en, prev_rd);
                chk1("mac_clr", mac_clr, prev_rd && (prev_tap == 0));
                chk1("mac_last", mac_last, prev_rd && (prev_tap == P_NTAP - 1));
                chk1("out_valid", out_valid, pend_out);
                if (pend_out) chka("out_addr", out_addr, q_out[0]);

                prev_rd  = do_rd;
                prev_tap = P_NTAP - rd_left;
                if (do_rd) begin
                    void'(q_pix.pop_front());
                    void'(q_wra.pop_front());
                    rd_left--;
                    if (rd_left == 0) ov_delay = 2;  // drain cycle, then output
                end
                if (do_wr) begin
                    void'(q_wr.pop_front());
                    wr_cnt++;
                    if (wr_cnt == P_NTAP) begin
                        exp_load = 0;
                        rd_left  = P_NTAP;
                    end
                end
                if (do_acc) begin
                    void'(q_out.pop_front());
                    pend_out = 0;
                    px_cnt++;
                    if (px_cnt % P_NPIX != 0) rd_left = P_NTAP;
                    else if (q_out.size() != 0) begin
                        exp_load = 1;
                        wr_cnt   = 0;
                    end else done_pend = 1;
                end
                if (!layer_active && transmission_start) begin
                    layer_active = 1;
                    exp_load     = 1;
                    wr_cnt       = 0;
                    px_cnt       = 0;
                    build_queues();
                end
                if (done_now) layer_active = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_random_layer(input string nm);
        int g = 0;
        while (!done && g < 3000) begin
            w_in_valid         = ($urandom_range(9) < 7);
            out_ready          = ($urandom_range(9) < 6);
            transmission_start = ($urandom_range(19) == 0);
            tick();
            g++;
        end
        transmission_start = 1'b0;
        chk1(nm, done, 1'b1);
    endtask

    initial begin
        int g;
        model_clear();
        fork
            monitor();
        join_none

        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();

        // ---- Layer 1: directed load gap, start in CONV, output stall ----
        w_in_valid = 1'b1;
        out_ready  = 1'b1;
        transmission_start = 1'b1;
        tick();
        transmission_start = 1'b0;
        #1;
        chk1("load_ready", w_in_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk1("load_wr_en", w_wr_en, 1'b1);
            chka("load_wr_addr", w_wr_addr, P_AW'(i));
            tick();
        end
        w_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("gap_wr_en", w_wr_en, 1'b0);
            chka("gap_wr_addr", w_wr_addr, 16'd4);
            tick();
        end
        w_in_valid = 1'b1;
        for (int i = 4; i < P_NTAP; i++) begin
            #1;
            chka("load2_wr_addr", w_wr_addr, P_AW'(i));
            tick();
        end
        #1;
        chk1("conv_entry_rd", pix_rd_en, 1'b1);
        chk1("conv_entry_ready", w_in_ready, 1'b0);
        for (int i = 0; i < P_NTAP; i++) begin
            #1;
            chka("win0_pix_addr", pix_addr, win0[i]);
            if (i == 5) transmission_start = 1'b1;
            if (i == 6) transmission_start = 1'b0;
            tick();
        end
        #1;
        chk1("drain_mac_last", mac_last, 1'b1);
        chk1("drain_rd", pix_rd_en, 1'b0);
        chk1("drain_valid", out_valid, 1'b0);
        tick();
        #1;
        chk1("px0_valid", out_valid, 1'b1);
        chka("px0_addr", out_addr, 16'd0);
        tick();
        out_ready = 1'b0;
        g = 0;
        while (!out_valid && g < 50) begin tick(); g++; end
        chk1("px1_valid_wait", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk1("stall_valid", out_valid, 1'b1);
            chka("stall_addr", out_addr, 16'd1);
            chk1("stall_rd", pix_rd_en, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        g = 0;
        while (!done && g < 2000) begin tick(); g++; end
        chk1("layer1_done", done, 1'b1);

        // ---- start in DONE ignored, start in following IDLE accepted ----
        transmission_start = 1'b1;
        #1;
        chk1("done_busy", busy, 1'b1);
        tick();
        #1;
        chk1("idle_after_done_busy", busy, 1'b0);
        chk1("idle_after_done_pulse", done, 1'b0);
        tick();
        transmission_start = 1'b0;
        #1;
        chk1("restart_busy", busy, 1'b1);
        chk1("restart_ready", w_in_ready, 1'b1);

        // ---- Layer 2: randomized handshakes and stray start pulses ----
        run_random_layer("layer2_done");
        tick();

        // ---- Layer 3: asynchronous reset in the middle of CONV ----
        w_in_valid = 1'b1;
        out_ready  = 1'b1;
        transmission_start = 1'b1;
        tick();
        transmission_start = 1'b0;
        g = 0;
        while (!pix_rd_en && g < 100) begin tick(); g++; end
        chk1("reach_conv", pix_rd_en, 1'b1);
        tick();
        tick();
        #1 rst = 1'b0;
        #1;
        chk1("async_busy", busy, 1'b0);
        chk1("async_rd", pix_rd_en, 1'b0);
        chk1("async_mac_en", mac_en, 1'b0);
        chk1("async_valid", out_valid, 1'b0);
        tick();
        tick();
        #1 rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("post_rst_idle", busy, 1'b0);
        end

        // ---- Layer 4: randomized again after reset ----
        transmission_start = 1'b1;
        tick();
        transmission_start = 1'b0;
        run_random_layer("layer4_done");
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
